axi_dma_copy_master: RTL and testbench
======================================

// Module: axi_dma_copy_master
// PURPOSE
//  AXI4 master that copies one burst of 1..256 beats from SRC to DST: an INCR read burst into an
//  internal beat buffer, then an INCR write burst of the same data. It is the initiator for the
//  axi_slave memory model and is driven by the DMA control logic through a start/done interface.
//  Transactions are strictly sequential: one outstanding transaction, read then write.
// PARAMETERS
//  AXI_ID_WD    2    ID width; all requests carry ID = TXN_ID
//  AXI_DATA_WD  32   data width, bits (power of 2, >= 8)
//  AXI_ADDR_WD  32   address width
//  AXI_STRB_WD  4    AXI_DATA_WD/8
//  TXN_ID       0    constant ARID/AWID value
// PORTS
//  M_AXI_ACLK     in   1        clock
//  M_AXI_ARESETN  in   1        asynchronous active-low reset
//  i_start        in   1        one-cycle request pulse
//  i_src_addr     in   AW       source byte address (beat-aligned)
//  i_dst_addr     in   AW       destination byte address (beat-aligned)
//  i_len          in   8        beats-1 (AXI LEN encoding)
//  o_busy         out  1        transfer in progress
//  o_done         out  1        one-cycle pulse at end of every accepted or rejected request
//  o_err          out  1        valid with o_done: 1 = failure
//  M_AXI_AR{ADDR,ID,BURST,SIZE,LEN,VALID} out, ARREADY in   read address channel
//  M_AXI_R{DATA,LAST,ID,RESP,VALID} in, RREADY out          read data channel
//  M_AXI_AW{ADDR,ID,BURST,SIZE,LEN,VALID} out, AWREADY in   write address channel
//  M_AXI_W{DATA,STRB,LAST,VALID} out, WREADY in             write data channel
//  M_AXI_B{ID,RESP,VALID} in, BREADY out                    write response channel
// BEHAVIOUR
//  Reset: all VALID/READY outputs 0, WLAST 0, o_busy/o_done/o_err 0, FSM=IDLE, buffer empty.
//   Reset asserted mid-transfer aborts immediately; no done pulse.
//  Constants: ARBURST=AWBURST=2'b01, ARSIZE=AWSIZE=log2(AXI_STRB_WD), WSTRB all ones.
//  FSM IDLE -> AR -> R -> AW -> W -> B -> IDLE.
//  IDLE: i_start sampled only here; ignored while o_busy=1. Reject (o_done=o_err=1 next cycle,
//   stay IDLE, no bus activity) if either address is misaligned or
//   addr[11:0] + (i_len+1)*AXI_STRB_WD > 4096 (4KB crossing). Otherwise latch src/dst/len,
//   o_busy=1, ARVALID=1 on the next cycle (start -> ARVALID latency 1).
//  AR: ARADDR/ARLEN/ARID held stable while ARVALID && !ARREADY; on fire -> R.
//  R: RREADY=1; each fire pushes RDATA into buffer, beat counter++. RRESP!=OKAY, RID!=TXN_ID,
//   or RLAST not matching beat==len set sticky err. Exit on beat==len fire: err -> finish
//   (skip write phase); else -> AW with AWVALID=1 next cycle.
//  AW: AWADDR=dst, AWLEN=len held until AWREADY; on fire -> W. No W beat before AW fire.
//  W: WVALID=1 while buffer non-empty; WDATA = buffer head, popped on fire; WLAST=1 exactly on
//   beat len; data/last stable while WVALID && !WREADY; after last fire -> B.
//  B: BREADY=1; on fire err |= (BRESP!=OKAY || BID!=TXN_ID) -> finish.
//  Finish: o_done=1 for one cycle, o_err=sticky err, o_busy=0, sticky err cleared, IDLE.
//   New i_start accepted the cycle after o_done.
//  Buffer depth 256 beats: never overflows; i_len=0 (single beat) and i_len=255 both legal.
//  Address arithmetic modulo 2^AW; beat counter 8 bits, compares with len, no wrap.
// STRUCTURE
//  axi_dma_pkg: BURST_INCR, RESP_OKAY/SLVERR, state enum, size-from-width function.
//  Sub-module dma_fifo (sync FIFO, DW x 256, async active-low reset, push/pop/empty/full).
//  FSM, counters and AXI outputs are registered in this module.
// TESTING (DW=32, TXN_ID=0, bench = axi_slave model)
//  src=0x100,dst=0x200,len=3, mem preset -> 4 beats read/written, mem[0x200..0x20F]=src data,
//   o_done=1,o_err=0.
//  len=0 -> ARLEN=0, single beat with RLAST and WLAST both on beat 0.
//  src=0xFF8,len=3 (crosses 4KB) -> o_done=o_err=1 next cycle, ARVALID never asserted.
//  Random ARREADY/RVALID/WREADY/BVALID stalls, len=255 -> 256-beat copy bit-exact, payload
//   stable during stalls.
//  Injected RRESP=2'b10 on beat 2 -> no AWVALID, o_done with o_err=1.
//  Reset pulsed during W phase -> all VALIDs 0 at once; next start works normally.

Source files
------------

// File: rtl/axi_dma_pkg.sv
// Shared AXI encodings, FSM state type and request-checking helpers for the DMA copy master.
package axi_dma_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_W,
    ST_B,
    ST_FIN
  } state_t;

  function automatic logic [2:0] size_from_strb(input int unsigned strb_wd);
    logic [2:0] s;
    s = '0;
    for (int unsigned i = 0; i < 8; i++)
      if ((32'd1 << i) == strb_wd) s = 3'(i);
    return s;
  endfunction

  // A burst may end exactly on the 4KB boundary but not run past it.
  function automatic logic crosses_4k(input logic [11:0] off, input logic [7:0] len,
                                      input int unsigned strb_wd);
    logic [31:0] span;
    span = (32'(len) + 32'd1) * strb_wd;
    return (32'(off) + span) > 32'd4096;
  endfunction

endpackage

// File: rtl/dma_fifo.sv
// Synchronous beat buffer holding one read burst until it is replayed on the write channel.
module dma_fifo #(
  parameter int unsigned DW      = 32,
  parameter int unsigned ADDR_WD = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full
);
  localparam int unsigned DEPTH = 1 << ADDR_WD;

  logic [DW-1:0]      mem [DEPTH];
  logic [ADDR_WD-1:0] wptr, rptr;
  logic [ADDR_WD:0]   cnt;
  logic               push_ok, pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign empty   = cnt == '0;
  assign full    = cnt[ADDR_WD];
  assign dout    = mem[rptr];

  always_ff @(posedge clk)
    if (push_ok) mem[wptr] <= din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/axi_dma_copy_master.sv
// AXI4 master copying one INCR burst (1..256 beats) from src to dst through an internal buffer.
module axi_dma_copy_master
  import axi_dma_pkg::*;
#(
  parameter int unsigned AXI_ID_WD   = 2,
  parameter int unsigned AXI_DATA_WD = 32,
  parameter int unsigned AXI_ADDR_WD = 32,
  parameter int unsigned AXI_STRB_WD = AXI_DATA_WD / 8,
  parameter int unsigned TXN_ID      = 0
) (
  input  logic                   M_AXI_ACLK,
  input  logic                   M_AXI_ARESETN,
  input  logic                   i_start,
  input  logic [AXI_ADDR_WD-1:0] i_src_addr,
  input  logic [AXI_ADDR_WD-1:0] i_dst_addr,
  input  logic [7:0]             i_len,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err,
  output logic [AXI_ADDR_WD-1:0] M_AXI_ARADDR,
  output logic [AXI_ID_WD-1:0]   M_AXI_ARID,
  output logic [1:0]             M_AXI_ARBURST,
  output logic [2:0]             M_AXI_ARSIZE,
  output logic [7:0]             M_AXI_ARLEN,
  output logic                   M_AXI_ARVALID,
  input  logic                   M_AXI_ARREADY,
  input  logic [AXI_DATA_WD-1:0] M_AXI_RDATA,
  input  logic                   M_AXI_RLAST,
  input  logic [AXI_ID_WD-1:0]   M_AXI_RID,
  input  logic [1:0]             M_AXI_RRESP,
  input  logic                   M_AXI_RVALID,
  output logic                   M_AXI_RREADY,
  output logic [AXI_ADDR_WD-1:0] M_AXI_AWADDR,
  output logic [AXI_ID_WD-1:0]   M_AXI_AWID,
  output logic [1:0]             M_AXI_AWBURST,
  output logic [2:0]             M_AXI_AWSIZE,
  output logic [7:0]             M_AXI_AWLEN,
  output logic                   M_AXI_AWVALID,
  input  logic                   M_AXI_AWREADY,
  output logic [AXI_DATA_WD-1:0] M_AXI_WDATA,
  output logic [AXI_STRB_WD-1:0] M_AXI_WSTRB,
  output logic                   M_AXI_WLAST,
  output logic                   M_AXI_WVALID,
  input  logic                   M_AXI_WREADY,
  input  logic [AXI_ID_WD-1:0]   M_AXI_BID,
  input  logic [1:0]             M_AXI_BRESP,
  input  logic                   M_AXI_BVALID,
  output logic                   M_AXI_BREADY
);
  localparam logic [AXI_ID_WD-1:0]   ID         = AXI_ID_WD'(TXN_ID);
  localparam logic [2:0]             SIZE       = size_from_strb(AXI_STRB_WD);
  localparam logic [AXI_ADDR_WD-1:0] ALIGN_MASK = AXI_ADDR_WD'(AXI_STRB_WD - 1);

  state_t                 state_q, state_d;
  logic [AXI_ADDR_WD-1:0] src_q, dst_q;
  logic [7:0]             len_q, rbeat_q, wbeat_q;
  logic                   err_q, rej_q;
  logic                   req_bad, accept, reject;
  logic                   ar_fire, r_fire, aw_fire, w_fire, b_fire;
  logic                   r_last, w_last, r_bad, b_bad;
  logic                   buf_empty, buf_full;

  assign req_bad = ((i_src_addr | i_dst_addr) & ALIGN_MASK) != '0
                || crosses_4k(i_src_addr[11:0], i_len, AXI_STRB_WD)
                || crosses_4k(i_dst_addr[11:0], i_len, AXI_STRB_WD);
  assign accept  = state_q == ST_IDLE && i_start && !req_bad;
  assign reject  = state_q == ST_IDLE && i_start && req_bad;

  assign ar_fire = M_AXI_ARVALID && M_AXI_ARREADY;
  assign r_fire  = M_AXI_RVALID && M_AXI_RREADY;
  assign aw_fire = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_fire  = M_AXI_WVALID && M_AXI_WREADY;
  assign b_fire  = M_AXI_BVALID && M_AXI_BREADY;
  assign r_last  = rbeat_q == len_q;
  assign w_last  = wbeat_q == len_q;
  assign r_bad   = M_AXI_RRESP != RESP_OKAY || M_AXI_RID != ID || M_AXI_RLAST != r_last;
  assign b_bad   = M_AXI_BRESP != RESP_OKAY || M_AXI_BID != ID;

  assign M_AXI_ARADDR  = src_q;
  assign M_AXI_ARID    = ID;
  assign M_AXI_ARBURST = BURST_INCR;
  assign M_AXI_ARSIZE  = SIZE;
  assign M_AXI_ARLEN   = len_q;
  assign M_AXI_AWADDR  = dst_q;
  assign M_AXI_AWID    = ID;
  assign M_AXI_AWBURST = BURST_INCR;
  assign M_AXI_AWSIZE  = SIZE;
  assign M_AXI_AWLEN   = len_q;
  assign M_AXI_WSTRB   = '1;

  dma_fifo #(.DW(AXI_DATA_WD), .ADDR_WD(8)) u_buf (
    .clk   (M_AXI_ACLK),
    .rst_n (M_AXI_ARESETN),
    .clr   (state_q == ST_FIN),
    .push  (r_fire),
    .din   (M_AXI_RDATA),
    .pop   (w_fire),
    .dout  (M_AXI_WDATA),
    .empty (buf_empty),
    .full  (buf_full)
  );

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) state_q <= ST_IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_AR;
      ST_AR:   if (ar_fire) state_d = ST_R;
      // A failed read skips the write phase entirely.
      ST_R:    if (r_fire && r_last) state_d = (err_q || r_bad) ? ST_FIN : ST_AW;
      ST_AW:   if (aw_fire) state_d = ST_W;
      ST_W:    if (w_fire && w_last) state_d = ST_B;
      ST_B:    if (b_fire) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      rbeat_q <= '0;
      wbeat_q <= '0;
      err_q   <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      rej_q <= reject;
      if (accept) begin
        src_q   <= i_src_addr;
        dst_q   <= i_dst_addr;
        len_q   <= i_len;
        rbeat_q <= '0;
        wbeat_q <= '0;
        err_q   <= 1'b0;
      end
      if (r_fire) begin
        if (!r_last) rbeat_q <= rbeat_q + 1'b1;
        if (r_bad)   err_q   <= 1'b1;
      end
      if (w_fire && !w_last) wbeat_q <= wbeat_q + 1'b1;
      if (b_fire && b_bad)   err_q   <= 1'b1;
      if (state_q == ST_FIN) err_q   <= 1'b0;
    end
  end

  always_comb begin
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_WLAST   = 1'b0;
    M_AXI_BREADY  = 1'b0;
    o_busy        = 1'b0;
    o_done        = rej_q;
    o_err         = rej_q;
    unique case (state_q)
      ST_AR: begin
        M_AXI_ARVALID = 1'b1;
        o_busy        = 1'b1;
      end
      ST_R: begin
        M_AXI_RREADY = !buf_full;
        o_busy       = 1'b1;
      end
      ST_AW: begin
        M_AXI_AWVALID = 1'b1;
        o_busy        = 1'b1;
      end
      ST_W: begin
        M_AXI_WVALID = !buf_empty;
        M_AXI_WLAST  = !buf_empty && w_last;
        o_busy       = 1'b1;
      end
      ST_B: begin
        M_AXI_BREADY = 1'b1;
        o_busy       = 1'b1;
      end
      ST_FIN: begin
        o_done = 1'b1;
        o_err  = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_dma_copy_master.sv
// Directed bench for axi_dma_copy_master with a behavioural AXI slave memory and protocol monitor.
module tb_axi_dma_copy_master;

  localparam int TO = 6000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] src_addr, dst_addr;
  logic [7:0]  len;
  logic        busy, done, err;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [1:0]  arid, awid, rid, bid, arburst, awburst, rresp, bresp;
  logic [2:0]  arsize, awsize;
  logic [7:0]  arlen, awlen;
  logic [3:0]  wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  always #5 clk = ~clk;

  axi_dma_copy_master dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .i_start(start), .i_src_addr(src_addr), .i_dst_addr(dst_addr), .i_len(len),
    .o_busy(busy), .o_done(done), .o_err(err),
    .M_AXI_ARADDR(araddr), .M_AXI_ARID(arid), .M_AXI_ARBURST(arburst),
    .M_AXI_ARSIZE(arsize), .M_AXI_ARLEN(arlen), .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RLAST(rlast), .M_AXI_RID(rid), .M_AXI_RRESP(rresp),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWID(awid), .M_AXI_AWBURST(awburst),
    .M_AXI_AWSIZE(awsize), .M_AXI_AWLEN(awlen), .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready)
  );

  // Slave memory (16KB, word addressed) and monitor counters
  logic [31:0] mem [0:4095];
  bit          stall_en;
  int          inj_beat;
  int          ar_cnt, aw_cnt, w_early, wlast_bad, stab_bad, attr_bad;
  logic [31:0] cap_araddr;
  logic [7:0]  cap_arlen;
  int          tests, fails;

  bit          rd_act, wr_act, b_pend, f_ar, f_r, f_aw, f_w, f_b, p_arv, p_awv, p_wv;
  int          rd_beat, wr_beat;
  logic [31:0] rd_addr, wr_addr, n_araddr, n_awaddr, n_wdata;
  logic [7:0]  rd_len, wr_len, n_arlen, n_awlen;
  logic        n_wlast;

  function automatic int widx(input logic [31:0] a, input int i);
    return (int'(a[13:2]) + i) & 4095;
  endfunction

  function automatic logic [31:0] pat(input int v, input int i);
    logic [31:0] x;
    x = {8'(v) + 8'hA0, 8'h5C, 16'(i)};
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave: applies handshakes seen at the previous posedge, then drives new responses at negedge
  initial begin
    {arready, rvalid, rlast, awready, wready, bvalid} = '0;
    rdata = '0; rresp = '0; rid = '0; bresp = '0; bid = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        {rd_act, wr_act, b_pend, f_ar, f_r, f_aw, f_w, f_b, p_arv, p_awv, p_wv} = '0;
        {arready, rvalid, rlast, awready, wready, bvalid} = '0;
        rresp = '0;
      end else begin
        if (p_arv && !f_ar && (!arvalid || araddr !== n_araddr || arlen !== n_arlen)) stab_bad++;
        if (p_awv && !f_aw && (!awvalid || awaddr !== n_awaddr || awlen !== n_awlen)) stab_bad++;
        if (p_wv && !f_w && (!wvalid || wdata !== n_wdata || wlast !== n_wlast)) stab_bad++;
        if (arvalid && (arburst !== 2'b01 || arsize !== 3'd2 || arid !== 2'd0)) attr_bad++;
        if (awvalid && (awburst !== 2'b01 || awsize !== 3'd2 || awid !== 2'd0)) attr_bad++;
        if (wvalid && wstrb !== 4'hF) attr_bad++;
        if (f_ar) begin
          ar_cnt++; cap_araddr = n_araddr; cap_arlen = n_arlen;
          rd_addr = n_araddr; rd_len = n_arlen; rd_beat = 0; rd_act = 1;
        end
        if (f_r) begin
          if (rd_beat == int'(rd_len)) rd_act = 0;
          else rd_beat++;
        end
        if (f_aw) begin
          aw_cnt++; wr_addr = n_awaddr; wr_len = n_awlen; wr_beat = 0; wr_act = 1;
        end
        if (f_w) begin
          if (!wr_act) w_early++;
          else begin
            mem[widx(wr_addr, wr_beat)] = n_wdata;
            if (n_wlast !== (wr_beat == int'(wr_len))) wlast_bad++;
            if (wr_beat == int'(wr_len)) begin wr_act = 0; b_pend = 1; end
            else wr_beat++;
          end
        end
        if (f_b) b_pend = 0;
        arready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        rvalid  = rd_act && (!stall_en || $urandom_range(0, 3) != 0);
        rdata   = rd_act ? mem[widx(rd_addr, rd_beat)] : '0;
        rlast   = rd_act && rd_beat == int'(rd_len);
        rresp   = (rd_act && rd_beat == inj_beat) ? 2'b10 : 2'b00;
        awready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        wready  = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        bvalid  = b_pend && (!stall_en || $urandom_range(0, 1) != 0);
        f_ar = arvalid && arready; n_araddr = araddr; n_arlen = arlen; p_arv = arvalid;
        f_r  = rvalid && rready;
        f_aw = awvalid && awready; n_awaddr = awaddr; n_awlen = awlen; p_awv = awvalid;
        f_w  = wvalid && wready; n_wdata = wdata; n_wlast = wlast; p_wv = wvalid;
        f_b  = bvalid && bready;
      end
    end
  end

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [7:0]  len;
    bit          stall;
    int          inj;
    bit          exp_rej;
    bit          exp_err;
  } vec_t;

  vec_t vecs [9];

  task automatic preset(input vec_t v, input int idx);
    for (int i = 0; i <= int'(v.len); i++) begin
      mem[widx(v.src, i)] = pat(idx, i);
      mem[widx(v.dst, i)] = 32'hDEAD0000 | 32'(i);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   cyc, ar0, aw0, bad;
    bit   got;
    logic e, arv1;
    string tag;
    tag = $sformatf("v%0d", idx);
    preset(v, idx);
    stall_en = v.stall; inj_beat = v.inj;
    ar0 = ar_cnt; aw0 = aw_cnt; e = 1'b0;
    @(negedge clk);
    start = 1'b1; src_addr = v.src; dst_addr = v.dst; len = v.len;
    @(negedge clk);
    start = 1'b0;
    arv1 = arvalid; cyc = 1; got = done;
    if (got) e = err;
    while (!got && cyc < TO) begin
      @(negedge clk);
      cyc++;
      if (done) begin got = 1; e = err; end
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_err"}, 32'(e), 32'(v.exp_err | v.exp_rej));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    if (v.exp_rej) begin
      check({tag, "_rej_latency"}, 32'(cyc), 32'd1);
      check({tag, "_no_ar"}, 32'(ar_cnt - ar0), 32'd0);
      check({tag, "_no_aw"}, 32'(aw_cnt - aw0), 32'd0);
    end else begin
      check({tag, "_ar_latency"}, 32'(arv1), 32'd1);
      check({tag, "_araddr"}, cap_araddr, v.src);
      check({tag, "_arlen"}, 32'(cap_arlen), 32'(v.len));
      bad = 0;
      for (int i = 0; i <= int'(v.len); i++)
        if (mem[widx(v.dst, i)] !== (v.exp_err ? (32'hDEAD0000 | 32'(i)) : pat(idx, i))) bad++;
      check({tag, "_dst_words_bad"}, 32'(bad), 32'd0);
      check({tag, "_aw_count"}, 32'(aw_cnt - aw0), v.exp_err ? 32'd0 : 32'd1);
    end
    check({tag, "_stable_viol"}, 32'(stab_bad), 32'd0);
    check({tag, "_wlast_viol"}, 32'(wlast_bad), 32'd0);
    check({tag, "_w_before_aw"}, 32'(w_early), 32'd0);
    check({tag, "_attr_viol"}, 32'(attr_bad), 32'd0);
  endtask

  initial begin
    int  cyc;
    bit  seen;
    tests = 0; fails = 0;
    rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    stall_en = 0; inj_beat = -1;
    //                src       dst       len   stall inj rej err
    vecs[0] = '{32'h100,  32'h200,  8'd3,   1'b0, -1, 1'b0, 1'b0};
    vecs[1] = '{32'h300,  32'h400,  8'd0,   1'b0, -1, 1'b0, 1'b0};
    vecs[2] = '{32'hFF8,  32'h200,  8'd3,   1'b0, -1, 1'b1, 1'b0};
    vecs[3] = '{32'h1000, 32'h2000, 8'd255, 1'b1, -1, 1'b0, 1'b0};
    vecs[4] = '{32'h500,  32'h600,  8'd7,   1'b1,  2, 1'b0, 1'b1};
    vecs[5] = '{32'h102,  32'h200,  8'd0,   1'b0, -1, 1'b1, 1'b0};
    vecs[6] = '{32'hFF0,  32'h800,  8'd3,   1'b0, -1, 1'b0, 1'b0};
    vecs[7] = '{32'h700,  32'hC00,  8'd255, 1'b0, -1, 1'b0, 1'b0};
    vecs[8] = '{32'h100,  32'h201,  8'd1,   1'b0, -1, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_ctrl", {26'd0, arvalid, awvalid, wvalid, wlast, rready, bready},
          32'd0);
    check("reset_status", {29'd0, busy, done, err}, 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("const_burst_size", {24'd0, arburst, arsize, awsize[2:0]}, {24'd0, 2'b01, 3'd2, 3'd2});
    check("const_wstrb", 32'(wstrb), 32'hF);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Reset in the middle of the write phase
    stall_en = 0; inj_beat = -1;
    preset(vecs[3], 20);
    @(negedge clk);
    start = 1'b1; src_addr = 32'h1000; dst_addr = 32'h2000; len = 8'd255;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!wvalid && cyc < 1000) begin @(negedge clk); cyc++; end
    check("midw_reached_w", 32'(wvalid), 32'd1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("midw_valids_off", {27'd0, arvalid, awvalid, wvalid, rready, bready}, 32'd0);
    check("midw_busy_off", {30'd0, busy, done}, 32'd0);
    seen = 0;
    repeat (2) begin @(negedge clk); if (done) seen = 1; end
    #2 rst_n = 1'b1;
    repeat (4) begin @(negedge clk); if (done || busy) seen = 1; end
    check("midw_no_done", 32'(seen), 32'd0);
    run_vec(vecs[0], 9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
